spike_aer_encoder: RTL and testbench

- Downstream consumer of the LIF neuron array: samples the N per-neuron spike lines each clock and serialises them into address-event (AER) words `{timestamp, neuron address}`.
- A round-robin arbiter feeds a small FIFO that drains over a valid/ready handshake to the output pins or a host.
- Lost events are counted, never silently hidden.

---
 rtl/spike_aer_encoder_if.sv | 12 +
 rtl/spike_aer_encoder.sv | 71 +++++++
 tb/tb_spike_aer_encoder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/spike_aer_encoder_if.sv
// spike_aer_encoder_if: AER output handshake carrying {timestamp, neuron address}.
interface spike_aer_encoder_if #(
  parameter int ADDR_W = 3,
  parameter int TS_W   = 8
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [TS_W-1:0]   ts;
  modport master(output valid, addr, ts, input ready);
  modport slave(input valid, addr, ts, output ready);
endinterface

// File: rtl/spike_aer_encoder.sv
// spike_aer_encoder: samples spike lines, round-robin arbitrates into an AER event FIFO, counts drops.
module spike_aer_encoder #(
  parameter int N_NEURONS  = 8,
  parameter int ADDR_W     = 3,
  parameter int TS_W       = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_NEURONS-1:0]          spike,
  spike_aer_encoder_if.master           aer,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [DROP_W-1:0]             drop_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [N_NEURONS-1:0] pending, gnt_vec, drop_vec;
  logic [ADDR_W-1:0]    rr, gnt;
  logic                 gnt_ok, pop, push;
  logic [TS_W-1:0]      ts;
  logic [ADDR_W-1:0]    addr_mem [FIFO_DEPTH];
  logic [TS_W-1:0]      ts_mem [FIFO_DEPTH];
  logic [PW-1:0]        rd_ptr, wr_ptr;
  logic [DROP_W:0]      drop_sum;
  assign aer.valid = fifo_level != '0;
  assign aer.addr  = addr_mem[rd_ptr];
  assign aer.ts    = ts_mem[rd_ptr];
  assign pop       = aer.valid & aer.ready;
  assign push      = gnt_ok & ((fifo_level != (PW+1)'(FIFO_DEPTH)) | pop);
  assign gnt_vec   = N_NEURONS'(push) << gnt;
  assign drop_vec  = spike & pending & ~gnt_vec;
  assign drop_sum  = {1'b0, drop_count} + (DROP_W+1)'($countones(drop_vec));
  // Scan from the farthest offset down so the nearest pending index after rr wins.
  always_comb begin
    gnt    = '0;
    gnt_ok = 1'b0;
    for (int k = N_NEURONS; k >= 1; k--) begin
      if (pending[rr + ADDR_W'(k)]) begin
        gnt    = rr + ADDR_W'(k);
        gnt_ok = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= '0;
      ts         <= '0;
      rr         <= ADDR_W'(N_NEURONS - 1);
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
      drop_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        addr_mem[i] <= '0;
        ts_mem[i]   <= '0;
      end
    end else begin
      ts         <= ts + TS_W'(1);
      pending    <= (pending & ~gnt_vec) | spike;
      drop_count <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
      fifo_level <= fifo_level + (PW+1)'(push) - (PW+1)'(pop);
      if (push) begin
        addr_mem[wr_ptr] <= gnt;
        ts_mem[wr_ptr]   <= ts;
        wr_ptr           <= wr_ptr + PW'(1);
        rr               <= gnt;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end
endmodule

// File: tb/tb_spike_aer_encoder.sv
// tb_spike_aer_encoder: scoreboard bench with a behavioural per-cycle reference model.
module tb_spike_aer_encoder;
  localparam int N = 8, DEPTH = 4, TSM = 256, DMAX = 255;
  typedef struct {int addr; int ts;} ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] spike = '0;
  logic [2:0] fifo_level;
  logic [7:0] drop_count;
  spike_aer_encoder_if #(.ADDR_W(3), .TS_W(8)) aer();
  spike_aer_encoder dut (
    .clk(clk), .rst(rst), .spike(spike), .aer(aer),
    .fifo_level(fifo_level), .drop_count(drop_count)
  );
  always #5 clk = ~clk;
  ev_t sbq[$];
  ev_t mon_e;
  int vectors = 0, miscompares = 0;
  bit armed = 1'b0;
  bit m_pend[N];
  int m_rr = N - 1, m_ts = 0, m_drop = 0, m_cnt = 0;
  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask
  // Model: one cycle of the encoder's observable rules, committed at the clock edge.
  task automatic step(input logic [7:0] s, input bit r, input bit rs = 1'b0);
    bit np[N];
    int nrr, nts, ndrop, ncnt, g, d;
    bit pp;
    ev_t e;
    spike = s;
    aer.ready = r;
    rst = rs;
    g = -1;
    e.addr = 0;
    e.ts = 0;
    if (rs) begin
      np = '{default: 1'b0};
      nrr = N - 1; nts = 0; ndrop = 0; ncnt = 0;
    end else begin
      pp = (m_cnt > 0) && r;
      if (m_cnt - int'(pp) < DEPTH)
        for (int k = 1; k <= N; k++)
          if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
      d = 0;
      for (int i = 0; i < N; i++) if (s[i] && m_pend[i] && i != g) d++;
      ndrop = (m_drop + d > DMAX) ? DMAX : m_drop + d;
      np = m_pend;
      if (g >= 0) np[g] = 1'b0;
      for (int i = 0; i < N; i++) if (s[i]) np[i] = 1'b1;
      nrr = (g >= 0) ? g : m_rr;
      ncnt = m_cnt - int'(pp) + ((g >= 0) ? 1 : 0);
      nts = (m_ts + 1) % TSM;
      e.addr = g;
      e.ts = m_ts;
    end
    @(posedge clk);
    if (rs) sbq.delete();
    else if (g >= 0) sbq.push_back(e);
    m_pend = np; m_rr = nrr; m_ts = nts; m_drop = ndrop; m_cnt = ncnt;
    #1;
  endtask
  always @(negedge clk) begin
    if (armed) begin
      check("fifo_level", int'(fifo_level), m_cnt);
      check("drop_count", int'(drop_count), m_drop);
      check("out_valid", int'(aer.valid), int'(m_cnt != 0));
      if (aer.valid && aer.ready) begin
        if (sbq.size() == 0) check("unexpected_event", 1, 0);
        else begin
          mon_e = sbq.pop_front();
          check("event_addr", int'(aer.addr), mon_e.addr);
          check("event_ts", int'(aer.ts), mon_e.ts);
        end
      end
    end
  end
  initial begin
    aer.ready = 1'b0;
    @(posedge clk);
    #1;
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    armed = 1'b1;
    check("reset_valid", int'(aer.valid), 0);
    check("reset_addr", int'(aer.addr), 0);
    check("reset_ts", int'(aer.ts), 0);
    check("reset_level", int'(fifo_level), 0);
    repeat (5) step(8'h00, 1'b1);
    step(8'h04, 1'b1);
    step(8'h00, 1'b1);
    check("single_valid", int'(aer.valid), 1);
    check("single_addr", int'(aer.addr), 2);
    check("single_ts", int'(aer.ts), 6);
    repeat (3) step(8'h00, 1'b1);
    check("single_level_after", int'(fifo_level), 0);
    step(8'hFF, 1'b1);
    repeat (12) step(8'h00, 1'b1);
    check("burst_drops", int'(drop_count), 0);
    repeat (10) step(8'h01, 1'b0);
    check("hold_drops", int'(drop_count), 5);
    check("hold_level", int'(fifo_level), 4);
    check("hold_addr", int'(aer.addr), 0);
    step(8'h08, 1'b0);
    step(8'h00, 1'b1);
    check("full_push_pop_level", int'(fifo_level), 4);
    repeat (10) step(8'h00, 1'b1);
    repeat (45) step(8'hFF, 1'b0);
    check("drop_saturate", int'(drop_count), 255);
    repeat (14) step(8'h00, 1'b1);
    step(8'hFF, 1'b0);
    repeat (3) step(8'h00, 1'b0);
    check("middrain_level", int'(fifo_level), 3);
    step(8'h00, 1'b1, 1'b1);
    check("middrain_reset_valid", int'(aer.valid), 0);
    check("middrain_reset_level", int'(fifo_level), 0);
    step(8'h81, 1'b1);
    step(8'h00, 1'b1);
    check("post_reset_first_addr", int'(aer.addr), 0);
    check("post_reset_first_ts", int'(aer.ts), 1);
    repeat (4) step(8'h00, 1'b1);
    repeat (400) step(8'($urandom & $urandom & $urandom), $urandom_range(0, 3) != 0);
    repeat (40) step(8'h00, 1'b1);
    check("drained_scoreboard", sbq.size(), 0);
    armed = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
